// File: rtl/mantle_reg_pkg.sv
// Shared definitions for the mantle register-pipeline generators.
// Holds the count-width helper and the per-edge priority encoding.
package mantle_reg_pkg;

  // Per-edge stage action, already resolved by rst > flush > ce > hold.
  typedef enum logic [2:0] {
    OP_RESET,
    OP_FLUSH_SHIFT,
    OP_FLUSH_HOLD,
    OP_SHIFT,
    OP_HOLD
  } stage_op_e;

  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic stage_op_e stage_op(input logic rst, input logic flush, input logic ce);
    if (rst)   return OP_RESET;
    if (flush) return ce ? OP_FLUSH_SHIFT : OP_FLUSH_HOLD;
    if (ce)    return OP_SHIFT;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/reg_stage_ce_srst.sv
// One pipeline stage: WIDTH-bit data register plus valid bit, with
// synchronous reset to INIT, flush (valid only) and clock enable.
module reg_stage_ce_srst
  import mantle_reg_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  stage_op_e        op;

  always_comb begin
    op     = stage_op(rst_i, flush_i, ce_i);
    // NOTE: hold values are assigned first so every path drives data_d/vld_d and no latch is inferred.
    data_d = data_q;
    vld_d  = vld_q;
    case (op)
      OP_RESET: begin
        data_d = INIT;
        vld_d  = 1'b0;
      end
      OP_FLUSH_SHIFT: begin
        data_d = d_i;
        vld_d  = 1'b0;
      end
      OP_FLUSH_HOLD: vld_d = 1'b0;
      OP_SHIFT: begin
        data_d = d_i;
        vld_d  = vld_i;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    vld_q  <= vld_d;
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/reg_pipe_ce_srst.sv
// DEPTH-deep clock-enabled delay line with per-stage valid, flush and an
// occupancy count; all outputs come straight from registers.
module reg_pipe_ce_srst
  import mantle_reg_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      ce_i,
  input  logic [WIDTH-1:0]          in_i,
  input  logic                      in_valid_i,
  input  logic                      flush_i,
  output logic [WIDTH-1:0]          out_o,
  output logic                      out_valid_o,
  output logic [WIDTH*DEPTH-1:0]    taps_o,
  output logic [CNT_W(DEPTH)-1:0]   count_o
);

  localparam int CW = CNT_W(DEPTH);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (k == 0) begin : g_head
      assign d_in = in_i;
      assign v_in = in_valid_i;
    end else begin : g_link
      assign d_in = stage_data[k-1];
      assign v_in = stage_vld[k-1];
    end

    reg_stage_ce_srst #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk     (clk),
      .rst_i   (rst_i),
      .ce_i    (ce_i),
      .flush_i (flush_i),
      .d_i     (d_in),
      .vld_i   (v_in),
      .q_o     (stage_data[k]),
      .vld_o   (stage_vld[k])
    );

    assign taps_o[k*WIDTH +: WIDTH] = stage_data[k];
  end

  // Modular add/sub is exact here: the result always lands in 0..DEPTH.
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (rst_i || flush_i) begin
      count_d = '0;
    end else if (ce_i) begin
      count_d = count_q + CW'(in_valid_i) - CW'(stage_vld[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign out_o       = stage_data[DEPTH-1];
  assign out_valid_o = stage_vld[DEPTH-1];
  assign count_o     = count_q;

endmodule

// File: doc/reg_pipe_ce_srst.md
# reg_pipe_ce_srst

Parametrised multi-stage register pipeline with clock enable, synchronous reset, per-stage valid tracking, flush and an occupancy count. It generalises the single clock-enabled register primitive into a DEPTH-deep delay line. Mantle/coreir generators instantiate it for retiming and latency-matching of Bits-typed datapaths where a lone register is not enough.

## Interface
- WIDTH, default 16: data width in bits; must be ≥1.
- DEPTH, default 4: number of register stages; must be ≥1.
- INIT, default 0 (WIDTH bits): value loaded into every data stage on reset.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- ce  input  1  clock enable; when low, all data and valid state holds.
- in  input  WIDTH  data into stage 0.
- in_valid  input  1  marks `in` as a real token.
- flush  input  1  clears all valid bits; data registers are untouched.
- out  output  WIDTH  stage DEPTH-1 data.
- out_valid  output  1  stage DEPTH-1 valid bit.
- taps  output  WIDTH*DEPTH  all stage data; stage k occupies bits [k*WIDTH +: WIDTH].
- count  output  $clog2(DEPTH+1)  number of stages currently valid.

## Operation
- State: data[0..DEPTH-1] (WIDTH bits each), vld[0..DEPTH-1], count register.
- Priority per edge: rst > flush > ce > hold.
- rst=1: every data[k]←INIT, vld all 0, count←0; ce, flush and in_valid are ignored.
- flush=1, rst=0: vld all 0 and count←0 regardless of ce.
  - If ce=1, data still shifts: data[0]←in, data[k]←data[k-1].
  - The incoming in_valid is dropped; a token presented in the flush cycle is lost.
- ce=1, no rst/flush: data[0]←in, vld[0]←in_valid, data[k]←data[k-1], vld[k]←vld[k-1] for k=1..DEPTH-1.
  - count←count + in_valid − vld[DEPTH-1].
  - Saturation of count is impossible by construction: 0 ≤ count ≤ DEPTH.
- ce=0, no rst/flush: all state holds; in and in_valid are ignored.
- Outputs are pure register reads (no combinational path from any input to any output).
- DEPTH=1 degenerates to a single register with a valid bit; count is 1 bit.

## Timing
- Latency in→out: DEPTH cycles of ce=1. Cycles with ce=0 add stall without loss.
- Throughput: one token per ce=1 cycle.
- Reset values, visible the cycle after rst is sampled high:
  - out=INIT, taps={DEPTH{INIT}}.
  - out_valid=0, count=0.
- Reset mid-operation discards all in-flight tokens. The first post-reset token appears at out after DEPTH ce-cycles.
- Simultaneous in_valid=1 and out_valid=1 with ce=1: count is unchanged.
- count and vld are always consistent: count equals the popcount of vld after every edge.

## Structure
- Shared package mantle_reg_pkg holds:
  - the count-width helper function, CNT_W(DEPTH)=$clog2(DEPTH+1);
  - the priority encoding constants, if used by sibling generators.
- One sub-module, reg_stage_ce_srst: a single WIDTH-bit data register plus valid bit with ce, rst (to INIT) and flush inputs.
  - It is generated DEPTH times and chained.
  - The count register lives in the top level.

## Test plan
- Reset: WIDTH=16, DEPTH=4, INIT=16'hA5A5; pulse rst with ce=1, in_valid=1 → next cycle out=16'hA5A5, all taps A5A5, out_valid=0, count=0.
- Streaming: ce=1, in=1,2,3,… with in_valid=1 → out=1 with out_valid=1 exactly 4 cycles after first input; count ramps 1,2,3,4 then stays 4.
- Stall: mid-stream hold ce=0 for 3 cycles while driving in=16'hFFFF, in_valid=1 → out, taps and count frozen; 16'hFFFF never enters; sequence resumes unbroken when ce=1.
- Flush with shift: count=4, assert flush and ce=1 with in=16'h0077, in_valid=1 → next cycle count=0, out_valid=0, taps[0]=16'h0077; no valid token emerges for the next 4 cycles unless new in_valid.
- Priority: assert rst, flush, ce, in_valid together → reset result only (INIT everywhere, count=0).
- Bubbles and DEPTH=1: alternate in_valid 1,0,1,0 with DEPTH=4 → out_valid pattern 1,0,1,0 delayed 4 cycles, count toggles 2↔2 in steady state. Repeat with DEPTH=1: out follows in after 1 cycle, count is 1 bit.
